// File: rtl/dsp_pkg.sv
// Shared constants and width helpers for the DSP chain that follows the 16-bit adder.
package dsp_pkg;

    // An adder result is {cout, sum}.
    localparam int SAMPLE_W = 17;

    // Width that holds the sum of 2^log2_len unsigned samples without overflow.
    function automatic int acc_width(input int in_w, input int log2_len);
        return in_w + log2_len;
    endfunction

endpackage

// File: rtl/acc_mean_round.sv
// Combinational block mean: (acc + LEN/2) >> LOG2_LEN, round half up and saturated.
// The result is zero for partial blocks. Used only when SUM_ACC_MEAN_EN is defined.
module acc_mean_round
    import dsp_pkg::*;
#(
    parameter int LOG2_LEN = 4,
    parameter int IN_W     = SAMPLE_W,
    localparam int ACC_W   = acc_width(IN_W, LOG2_LEN)
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [LOG2_LEN:0] i_count,
    output logic [IN_W-1:0]   o_mean
);

    localparam logic [ACC_W:0]    HALF     = (ACC_W+1)'(1 << (LOG2_LEN - 1));
    localparam logic [LOG2_LEN:0] FULL_CNT = (LOG2_LEN+1)'(1 << LOG2_LEN);

    logic [ACC_W:0] w_rounded;
    logic [ACC_W:0] w_shifted;
    logic           w_full;
    logic           w_sat;

    // One spare bit so adding the half-LSB can never wrap.
    assign w_rounded = {1'b0, i_acc} + HALF;
    assign w_shifted = w_rounded >> LOG2_LEN;
    assign w_full    = (i_count == FULL_CNT);
    assign w_sat     = |w_shifted[ACC_W:IN_W];

    always_comb begin
        o_mean = '0;
        if (w_full) begin
            o_mean = w_sat ? '1 : w_shifted[IN_W-1:0];
        end
    end

endmodule

// File: rtl/sum_block_accumulator.sv
// Integrate-and-dump of {cout, sum} samples in blocks of 2^LOG2_LEN, with flush and a
// valid/ready output register. Defining SUM_ACC_MEAN_EN adds the rounded mean port out_mean.
module sum_block_accumulator
    import dsp_pkg::*;
#(
    parameter int LOG2_LEN = 4,
    parameter int IN_W     = SAMPLE_W,
    localparam int ACC_W   = acc_width(IN_W, LOG2_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_sum,
    input  logic              in_cout,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [LOG2_LEN:0] out_count
`ifdef SUM_ACC_MEAN_EN
    ,
    output logic [IN_W-1:0]   out_mean
`endif
);

    localparam logic [LOG2_LEN:0] LAST_CNT = (LOG2_LEN+1)'((1 << LOG2_LEN) - 1);

    logic [ACC_W-1:0]  r_acc;
    logic [LOG2_LEN:0] r_count;
    logic              r_out_valid;
    logic [ACC_W-1:0]  r_out_acc;
    logic [LOG2_LEN:0] r_out_count;

    logic [ACC_W-1:0]  w_sample;
    logic              w_accept;
    logic              w_flush;
    logic              w_xfer;
    logic [ACC_W-1:0]  w_sum;
    logic [LOG2_LEN:0] w_cnt_next;
    logic              w_emit;

    // The output register is free when empty or being drained this cycle.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_flush    = flush && in_ready;
    assign w_xfer     = r_out_valid && out_ready;
    assign w_sample   = ACC_W'({in_cout, in_sum});
    assign w_sum      = r_acc + (w_accept ? w_sample : '0);
    assign w_cnt_next = r_count + {{LOG2_LEN{1'b0}}, w_accept};
    // A flush only emits when something (held or arriving) is in the block.
    assign w_emit     = (w_accept && (r_count == LAST_CNT))
                      || (w_flush && (w_cnt_next != '0));

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
        end else if (w_emit) begin
            r_out_acc   <= w_sum;
            r_out_count <= w_cnt_next;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_acc   <= w_sum;
                r_count <= w_cnt_next;
            end
            if (w_xfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;

`ifdef SUM_ACC_MEAN_EN
    logic [IN_W-1:0] w_mean;
    logic [IN_W-1:0] r_out_mean;

    acc_mean_round #(
        .LOG2_LEN (LOG2_LEN),
        .IN_W     (IN_W)
    ) u_mean (
        .i_acc   (w_sum),
        .i_count (w_cnt_next),
        .o_mean  (w_mean)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_mean <= '0;
        end else if (w_emit) begin
            r_out_mean <= w_mean;
        end
    end

    assign out_mean = r_out_mean;
`endif

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Randomised and directed bench for sum_block_accumulator (LOG2_LEN=4) against a block-level
// reference model. Honours SUM_ACC_MEAN_EN to also check out_mean.
module tb_sum_block_accumulator;

    localparam int LOG2_LEN = 4;
    localparam int LEN      = 1 << LOG2_LEN;
    localparam int ACC_W    = 17 + LOG2_LEN;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_sum = '0;
    logic              in_cout = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_acc;
    logic [LOG2_LEN:0] out_count;
`ifdef SUM_ACC_MEAN_EN
    logic [16:0]       out_mean;
`endif

    sum_block_accumulator #(.LOG2_LEN(LOG2_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count)
`ifdef SUM_ACC_MEAN_EN
        ,
        .out_mean  (out_mean)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the running block (sum, sample count) and the result on offer.
    longint m_sum   = 0;
    int     m_cnt   = 0;
    bit     m_valid = 0;
    longint m_acc   = 0;
    int     m_count = 0;
    longint m_mean  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input int s, input bit fl, input bit ordy, input bit rst);
        bit exp_ready;
        bit acc_s;
        bit acc_f;
        @(negedge clk);
        in_valid  = v;
        {in_cout, in_sum} = s[16:0];
        flush     = fl;
        out_ready = ordy;
        reset     = rst;
        #1;
        exp_ready = !m_valid || ordy;
        check("in_ready", longint'(in_ready), longint'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_sum = 0; m_cnt = 0; m_valid = 0; m_acc = 0; m_count = 0; m_mean = 0;
        end else begin
            acc_s = v && exp_ready;
            acc_f = fl && exp_ready;
            if (m_valid && ordy) m_valid = 0;
            if (acc_s) begin
                m_sum += s;
                m_cnt++;
            end
            if (m_cnt == LEN || (acc_f && m_cnt > 0)) begin
                m_valid = 1;
                m_acc   = m_sum;
                m_count = m_cnt;
                m_mean  = (m_cnt == LEN) ? (m_sum + LEN / 2) / LEN : 0;
                if (m_mean > 17'h1FFFF) m_mean = 17'h1FFFF;
                m_sum = 0;
                m_cnt = 0;
            end
        end
        #1;
        check("out_valid", longint'(out_valid), longint'(m_valid));
        if (m_valid || rst) begin
            check("out_acc", longint'(out_acc), m_acc);
            check("out_count", longint'(out_count), longint'(m_count));
`ifdef SUM_ACC_MEAN_EN
            check("out_mean", longint'(out_mean), m_mean);
`endif
        end
    endtask

    initial begin
        // Reset state.
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_acc", longint'(out_acc), 0);

        // 16 samples of {cout=1, sum=0}: total 2^20, visible the cycle after the 16th.
        for (int i = 0; i < LEN; i++) step(1, 17'h10000, 0, 1, 0);
        check("blk_carry_acc", longint'(out_acc), 64'h100000);
        check("blk_carry_cnt", longint'(out_count), 16);
`ifdef SUM_ACC_MEAN_EN
        check("blk_carry_mean", longint'(out_mean), 64'h10000);
`endif

        // 32 max samples back to back: two results, in_ready held high throughout.
        for (int i = 0; i < 2 * LEN; i++) begin
            step(1, 17'h1FFFF, 0, 1, 0);
            if (i == LEN - 1) check("blk_max_acc", longint'(out_acc), 64'h1FFFF0);
        end
        check("blk_max_acc2", longint'(out_acc), 64'h1FFFF0);
        step(0, 0, 0, 1, 0);

        // 10, 20, 30 then flush without a sample; then an empty flush emits nothing.
        step(1, 10, 0, 1, 0);
        step(1, 20, 0, 1, 0);
        step(1, 30, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check("flush_acc", longint'(out_acc), 60);
        check("flush_cnt", longint'(out_count), 3);
        step(0, 0, 1, 1, 0);
        check("flush_empty_valid", longint'(out_valid), 0);
        // Flush together with a sample, and flush together with block completion.
        step(1, 4, 0, 1, 0);
        step(1, 5, 1, 1, 0);
        check("flush_smp_acc", longint'(out_acc), 9);
        for (int i = 0; i < LEN; i++) step(1, 2, (i == LEN - 1), 1, 0);
        check("flush_full_cnt", longint'(out_count), 16);
        step(0, 0, 0, 1, 0);

        // Stall: block completes under out_ready=0; next sample waits until the drain.
        for (int i = 0; i < LEN; i++) step(1, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 7, 0, 0, 0);
        check("stall_acc", longint'(out_acc), 80);
        step(1, 7, 0, 1, 0);
        step(0, 0, 1, 1, 0);
        check("stall_drain_acc", longint'(out_acc), 7);

        // Reset discards a partial block and a held result.
        for (int i = 0; i < 5; i++) step(1, 100, 0, 1, 0);
        step(1, 100, 0, 1, 1);
        for (int i = 0; i < LEN; i++) step(1, 1, 0, 0, 0);
        check("rst_partial_acc", longint'(out_acc), 16);
        step(0, 0, 0, 0, 1);
        check("rst_hold_valid", longint'(out_valid), 0);

        // Fifteen ones and a nine: total 24, mean rounds 1.5 up to 2.
        for (int i = 0; i < LEN; i++) step(1, (i == LEN - 1) ? 9 : 1, 0, 1, 0);
        check("mean_blk_acc", longint'(out_acc), 24);
`ifdef SUM_ACC_MEAN_EN
        check("mean_blk_mean", longint'(out_mean), 2);
`endif

        // Randomised traffic with back-pressure, flushes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int s;
            s = ($urandom_range(0, 7) == 0) ? 17'h1FFFF : int'($urandom_range(0, 17'h1FFFF));
            step($urandom_range(0, 9) < 7, s, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 299) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Sits directly downstream of the 16-bit ripple-carry adder stage.
- Consumes each 17-bit result {cout, sum} as an unsigned sample and accumulates blocks of 2^LOG2_LEN samples.
- Emits the block total through a valid/ready output register.
- Provides the first sequential DSP stage (block sum / decimating integrate-and-dump) after the adder.

Parameters:
- LOG2_LEN, 4: log2 of block length; LEN = 2^LOG2_LEN samples per block; legal range 1..8.
- IN_W, 17: sample width, i.e. adder {cout, sum}; not intended to be overridden.
- ACC_W, IN_W+LOG2_LEN: accumulator/output width (localparam, derived). Guarantees no overflow.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_sum/in_cout.
- in_ready  output  1  block can accept a sample or flush this cycle.
- in_sum  input  16  adder sum.
- in_cout  input  1  adder carry-out; sample = {in_cout, in_sum}, zero-extended.
- flush  input  1  request early emission of a partial block; qualified by in_ready.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  block total.
- out_count  output  LOG2_LEN+1  number of samples in out_acc, 1..LEN.

Behaviour:
- Reset (synchronous, active-high), applied on the next edge:
  - acc=0, count=0, out_valid=0, out_acc=0, out_count=0.
  - Any partial block and any pending result are discarded.
  - Reset dominates all other inputs in the same cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational from out_ready only; no path from in_valid/flush).
  - A sample is accepted when in_valid && in_ready; a flush is accepted when flush && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Accept without completion: acc <= acc + sample; count <= count+1.
- Block completion (accepted sample with count==LEN-1):
  - out_acc <= acc+sample; out_count <= LEN; out_valid <= 1.
  - acc <= 0; count <= 0.
- Flush accepted:
  - If sample also accepted: emit acc+sample with out_count=count+1.
  - Else if count>0: emit acc with out_count=count.
  - Else (empty, no sample): no-op, out_valid unaffected.
  - In every emitting case, acc and count clear.
- Flush coinciding with block completion: single emission of LEN samples; no extra empty emission.
- Latency: result visible (out_valid=1) on the cycle after the last sample is accepted.
- Output transfer with no new emission: out_valid <= 0. Same-cycle transfer plus new emission: out_valid stays 1 and new data loads (full throughput, 1 sample/cycle under out_ready=1).
- Output stability: out_acc and out_count are stable while out_valid && !out_ready.
- Stall: while out_valid && !out_ready, in_ready=0; the partial accumulator is held.
- States:
  - ACCUM (out_valid=0).
  - HOLD (out_valid=1); HOLD->ACCUM on transfer without new emission.
  - Coded as the out_valid flop plus count.
- Arithmetic: unsigned and zero-extended; max total LEN*(2^17-1) fits ACC_W exactly; no saturation needed.

Optional Feature:
- Macro: SUM_ACC_MEAN_EN.
- Defined:
  - Adds output port out_mean [IN_W-1:0], registered alongside out_acc.
  - For full blocks: out_mean = (out_acc + 2^(LOG2_LEN-1)) >> LOG2_LEN (round half up, saturated to 2^17-1).
  - For partial blocks (out_count<LEN): out_mean = 0.
  - Reset value 0.
- Undefined: port absent and no rounding logic; all other behaviour identical.

Decomposition:
- Shared package dsp_pkg:
  - SAMPLE_W=17 constant.
  - Helper function for ACC_W derivation.
- Module: sum_block_accumulator.
  - Holds control, accumulator and output register.
  - The mean/round path, when SUM_ACC_MEAN_EN is defined, is a natural sub-module: acc_mean_round (combinational, parameterised on LOG2_LEN).
- No other sub-modules.

Test Plan:
- LOG2_LEN=4, out_ready=1, 16 back-to-back samples {cout=1,sum=0x0000} -> one cycle after 16th: out_valid=1, out_acc=0x100000, out_count=16, out_mean=0x10000.
- 16 samples of 0x1FFFF -> out_acc=0x1FFFF0 (no overflow); out_mean=0x1FFFF; 32 samples continuous -> two results, no bubbles, in_ready constant 1.
- Samples 10, 20, 30, then flush with in_valid=0 -> out_acc=60, out_count=3, out_mean=0; flush with count=0 and in_valid=0 -> no out_valid pulse.
- Complete a block with out_ready=0 -> in_ready=0 next cycle; offered sample held, not accepted; out_acc stable; raise out_ready -> transfer, sample accepted same cycle.
- Accept 5 samples, assert reset 1 cycle, then 16 samples of 1 -> out_acc=16 (pre-reset samples discarded); reset during HOLD -> out_valid=0 next cycle.
- Fifteen samples of 1 plus one of 9 (total 24), SUM_ACC_MEAN_EN defined -> out_mean=2 (rounded); without macro, port absent and out_acc=24.
